// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative multiply/divide unit with HI/LO registers.
//
// Decodes R-type (aluop == 2'b10) funct codes MFHI/MTHI/MFLO/MTLO/MULT/MULTU
// and, when the MULDIV_DIV_EN macro is defined, DIV/DIVU. Multiply is shift-add
// and divide is restoring; both take one bit per cycle on magnitudes in the
// {HI,LO} accumulator, then a FIX cycle applies the signs.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   aluop    ALU op class; unit acts only on 2'b10
//   funct    R-type funct field
//   start    instruction valid in EX this cycle
//   rs_val   operand A (multiplicand / dividend / MT source)
//   rt_val   operand B (multiplier / divisor)
//   busy     operation in progress, HI/LO not yet valid
//   done     one-cycle pulse when MULT*/DIV* results land in HI/LO
//   mf_val   registered HI or LO for MFHI/MFLO
//   div0     sticky divide-by-zero flag (tied 0 without MULDIV_DIV_EN)
//   illegal  one-cycle pulse for an accepted funct this build lacks
module muldiv_unit #(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   aluop,
  input  logic [5:0]   funct,
  input  logic         start,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] rt_val,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] mf_val,
  output logic         div0,
  output logic         illegal
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

`ifdef MULDIV_DIV_EN
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIX, S_DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d, b_q, b_d, mf_q, mf_d;
  logic             neg_q, neg_d, ill_q, ill_d;
  logic             accept, sgn, a_neg, b_neg;
  logic [W-1:0]     a_mag, b_mag;
  logic [W:0]       sum;
`ifdef MULDIV_DIV_EN
  logic             rneg_q, rneg_d, dz_q, dz_d, div_q, div_d, div0_q, div0_d;
  logic [W:0]       rem, diff;
`endif

  assign accept = start && (aluop == 2'b10) && (state_q == S_IDLE);
  // Even funct codes (MULT/DIV) are the signed variants.
  assign sgn    = ~funct[0];
  assign a_neg  = sgn & rs_val[W-1];
  assign b_neg  = sgn & rt_val[W-1];
  assign a_mag  = a_neg ? -rs_val : rs_val;
  assign b_mag  = b_neg ? -rt_val : rt_val;
  assign sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
`ifdef MULDIV_DIV_EN
  assign rem    = {hi_q, lo_q[W-1]};
  assign diff   = rem - {1'b0, b_q};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    mf_d    = mf_q;
    neg_d   = neg_q;
    ill_d   = 1'b0;
`ifdef MULDIV_DIV_EN
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    div_d   = div_q;
    div0_d  = div0_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (funct)
            F_MFHI: mf_d = hi_q;
            F_MTHI: hi_d = rs_val;
            F_MFLO: mf_d = lo_q;
            F_MTLO: lo_d = rs_val;
            F_MULT, F_MULTU: begin
              hi_d    = '0;
              lo_d    = a_mag;
              b_d     = b_mag;
              neg_d   = a_neg ^ b_neg;
              cnt_d   = '0;
              state_d = S_MUL;
`ifdef MULDIV_DIV_EN
              div_d   = 1'b0;
`endif
            end
            F_DIV, F_DIVU: begin
`ifdef MULDIV_DIV_EN
              hi_d    = '0;
              lo_d    = a_mag;
              b_d     = b_mag;
              neg_d   = a_neg ^ b_neg;
              rneg_d  = a_neg;
              dz_d    = (rt_val == '0);
              div_d   = 1'b1;
              div0_d  = 1'b0;
              cnt_d   = '0;
              state_d = S_DIV;
`else
              ill_d   = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        {hi_d, lo_d} = {sum, lo_q[W-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W-1)) state_d = S_FIX;
      end
`ifdef MULDIV_DIV_EN
      S_DIV: begin
        // Restoring step: keep the trial difference only if it did not borrow.
        hi_d  = diff[W] ? rem[W-1:0] : diff[W-1:0];
        lo_d  = {lo_q[W-2:0], ~diff[W]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W-1)) state_d = S_FIX;
      end
`endif
      S_FIX: begin
        state_d = S_DONE;
`ifdef MULDIV_DIV_EN
        if (div_q) begin
          // Divide by zero leaves quotient all-ones; remainder sign fix restores rs_val.
          if (neg_q && !dz_q) lo_d = -lo_q;
          if (rneg_q)         hi_d = -hi_q;
          div0_d = dz_q;
        end else if (neg_q) begin
          {hi_d, lo_d} = -{hi_q, lo_q};
        end
`else
        if (neg_q) {hi_d, lo_d} = -{hi_q, lo_q};
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      mf_q    <= '0;
      neg_q   <= 1'b0;
      ill_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      div_q   <= 1'b0;
      div0_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      mf_q    <= mf_d;
      neg_q   <= neg_d;
      ill_q   <= ill_d;
`ifdef MULDIV_DIV_EN
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      div_q   <= div_d;
      div0_q  <= div0_d;
`endif
    end
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done    = (state_q == S_DONE);
  assign mf_val  = mf_q;
  assign illegal = ill_q;
`ifdef MULDIV_DIV_EN
  assign div0    = div0_q;
`else
  assign div0    = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  aluop = 2'b00;
  logic [5:0]  funct = 6'h00;
  logic        start = 1'b0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        busy, done, div0, illegal;
  logic [31:0] mf_val;
  int          tests = 0, fails = 0;
  logic [31:0] hi, lo;

  muldiv_unit #(.W(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .aluop(aluop), .funct(funct), .start(start),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
    .mf_val(mf_val), .div0(div0), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one accept edge and returns at the next negedge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    aluop = 2'b10; funct = f; rs_val = a; rt_val = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rs_val = 32'hA5A5A5A5; rt_val = 32'h5A5A5A5A;
  endtask

  task automatic rd(output logic [31:0] h, output logic [31:0] l);
    issue(6'h10, '0, '0); h = mf_val;
    issue(6'h12, '0, '0); l = mf_val;
  endtask

  // Accept edge, 32 iteration edges, FIX edge -> DONE on edge 34; then back to IDLE.
  task automatic long_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    issue(f, a, b);
    chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    repeat (32) @(negedge clk);
    chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mf", mf_val, 32'd0);
    chk("rst_div0", {31'd0, div0}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MULTU all-ones squared
    long_op("multu", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    rd(hi, lo);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    // Reset mid-MULT aborts and clears HI/LO
    issue(6'h18, 32'd5, 32'd7);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(hi, lo);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);

    // MULT -7*3 with an MTHI attempted while busy (must be ignored)
    issue(6'h18, 32'hFFFFFFF9, 32'd3);
    repeat (4) @(negedge clk);
    issue(6'h11, 32'h0000DEAD, '0);
    chk("mult_busy_ign", {31'd0, busy}, 32'd1);
    repeat (27) @(negedge clk);
    chk("mult_done_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("mult_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    rd(hi, lo);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);

    // MULT MIN_INT * MIN_INT = 2^62
    long_op("multmin", 6'h18, 32'h80000000, 32'h80000000);
    rd(hi, lo);
    chk("multmin_hi", hi, 32'h40000000);
    chk("multmin_lo", lo, 32'h00000000);

    // MTHI then MFHI, MTLO then MFLO; single cycle, never busy
    issue(6'h11, 32'h00001234, '0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    issue(6'h10, '0, '0);
    chk("mfhi_val", mf_val, 32'h00001234);
    chk("mfhi_busy", {31'd0, busy}, 32'd0);
    issue(6'h13, 32'hCAFEF00D, '0);
    chk("mf_hold", mf_val, 32'h00001234);
    issue(6'h12, '0, '0);
    chk("mflo_val", mf_val, 32'hCAFEF00D);

    // Unsupported funct: no action
    issue(6'h20, 32'h11111111, '0);
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_illegal", {31'd0, illegal}, 32'd0);

`ifdef MULDIV_DIV_EN
    long_op("div", 6'h1A, 32'hFFFFFFF9, 32'd2);
    rd(hi, lo);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_div0", {31'd0, div0}, 32'd0);

    issue(6'h1B, 32'd100, 32'd0);
    chk("divu0_ill", {31'd0, illegal}, 32'd0);
    repeat (32) @(negedge clk);
    chk("divu0_div0_early", {31'd0, div0}, 32'd0);
    @(negedge clk);
    chk("divu0_done", {31'd0, done}, 32'd1);
    chk("divu0_div0", {31'd0, div0}, 32'd1);
    @(negedge clk);
    rd(hi, lo);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'd100);
    chk("div0_sticky", {31'd0, div0}, 32'd1);

    long_op("divov", 6'h1A, 32'h80000000, 32'hFFFFFFFF);
    chk("div0_cleared", {31'd0, div0}, 32'd0);
    rd(hi, lo);
    chk("divov_lo", lo, 32'h80000000);
    chk("divov_hi", hi, 32'h00000000);

    long_op("divu", 6'h1B, 32'd100, 32'd7);
    rd(hi, lo);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
`else
    // DIVU is illegal in this build; HI=0x1234, LO=0xCAFEF00D must survive
    issue(6'h1B, 32'd100, 32'd0);
    chk("divu_illegal", {31'd0, illegal}, 32'd1);
    chk("divu_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("divu_ill_pulse", {31'd0, illegal}, 32'd0);
    chk("divu_busy2", {31'd0, busy}, 32'd0);
    chk("divu_div0", {31'd0, div0}, 32'd0);
    rd(hi, lo);
    chk("divu_hi_keep", hi, 32'h00001234);
    chk("divu_lo_keep", lo, 32'hCAFEF00D);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
